button_conditioner: RTL and testbench

- Front-end stage directly upstream of the game core. It conditions the raw, asynchronous, bouncing start and pattern buttons.
- Per button: 2-flop synchroniser, then debounce FSM, then clean level plus one-cycle press/release pulses.
- Also arbitrates simultaneous presses into a single encoded pattern event (code + valid) for the input handler and the FSMs.

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/debounce_cell.sv | 146 ++++++++++++++
 rtl/button_conditioner.sv | 81 ++++++++
 tb/tb_button_conditioner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioner front end.
// Optional stuck detection: BUTTON_CONDITIONER_STUCK_DETECT_EN.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        REL,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } db_state_t;

    localparam int START_IDX = 0;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, debounce FSM, level and press/release pulses.
// Hold counter and stuck flag exist only with BUTTON_CONDITIONER_STUCK_DETECT_EN.
module debounce_cell
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STUCK_CYCLES    = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls,
    output logic stuck,
    output logic level_d,
    output logic press_d
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || STUCK_CYCLES < 1) begin : g_bad_cfg
        $error("debounce_cell: bad DEBOUNCE_CYCLES/STUCK_CYCLES");
    end

    logic [1:0]    sync;
    logic          s;
    db_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          rls_d;

`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
    localparam int HW = $clog2(STUCK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STUCK_CYCLES - 1);
    logic [HW-1:0] hold, hold_d;
    logic          stuck_d;
`else
    assign stuck = 1'b0;
`endif

    assign s = sync[1];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = level;
        press_d = 1'b0;
        rls_d   = 1'b0;
`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
        hold_d  = hold;
        stuck_d = stuck;
`endif
        unique case (state)
            REL: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt == LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
                    hold_d  = '0;
`endif
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CW'(1);
`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
                    hold_d  = '0;
`endif
                end
`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
                else if (!stuck) begin
                    // A stuck button drops its level silently.
                    if (hold == HOLD_LAST) begin
                        stuck_d = 1'b1;
                        level_d = 1'b0;
                    end else begin
                        hold_d = hold + 1'b1;
                    end
                end
`endif
            end
            REL_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt == LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rls_d   = !stuck;
`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
                    stuck_d = 1'b0;
`endif
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= REL;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            press <= press_d;
            rls   <= rls_d;
        end
    end

`ifdef BUTTON_CONDITIONER_STUCK_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold  <= '0;
            stuck <= 1'b0;
        end else begin
            hold  <= hold_d;
            stuck <= stuck_d;
        end
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces all buttons and arbitrates pattern presses into one coded event.
// Optional stuck detection: BUTTON_CONDITIONER_STUCK_DETECT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = 9,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CODE_W          = 3,
    parameter int STUCK_CYCLES    = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  raw_btn,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    output logic [N_BTN-1:0]  btn_release,
    output logic              pat_valid,
    output logic [CODE_W-1:0] pat_code,
    output logic              multi_press,
    output logic [N_BTN-1:0]  stuck
);

    localparam logic [N_BTN-1:0] PAT_MASK = ~(N_BTN'(1) << START_IDX);

    if (N_BTN < 2 || N_BTN - 1 > 2 ** CODE_W) begin : g_bad_cfg
        $error("button_conditioner: CODE_W too narrow for N_BTN");
    end

    logic [N_BTN-1:0]  level_d, press_d;
    logic [N_BTN-1:0]  p, h;
    int unsigned       n_press;
    logic              valid_d, multi_d;
    logic [CODE_W-1:0] code_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_btn[g]),
            .level  (btn_level[g]),
            .press  (btn_press[g]),
            .rls    (btn_release[g]),
            .stuck  (stuck[g]),
            .level_d(level_d[g]),
            .press_d(press_d[g])
        );
    end

    // Arbitrate on next-cycle pulses so the event lines up with btn_press.
    always_comb begin
        p       = press_d & PAT_MASK;
        h       = level_d & ~press_d & PAT_MASK;
        n_press = popcount(32'(p));
        valid_d = (n_press == 1) && (h == '0);
        multi_d = (n_press != 0) && !valid_d;
        code_d  = pat_code;
        for (int i = 0; i < N_BTN; i++) begin
            if (i != START_IDX && p[i]) begin
                code_d = CODE_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_valid   <= 1'b0;
            multi_press <= 1'b0;
            pat_code    <= '0;
        end else begin
            pat_valid   <= valid_d;
            multi_press <= multi_d;
            if (valid_d) begin
                pat_code <= code_d;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// all cycles compared against a run-length reference model.
module tb_button_conditioner;

    localparam int N  = 9;
    localparam int D  = 1000;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  raw_btn = '0;
    logic [N-1:0]  btn_level, btn_press, btn_release, stuck;
    logic          pat_valid, multi_press;
    logic [CW-1:0] pat_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .CODE_W(CW),
        .STUCK_CYCLES(65535)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_btn(raw_btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .pat_valid(pat_valid),
        .pat_code(pat_code),
        .multi_press(multi_press),
        .stuck(stuck)
    );

    // Reference: a level flips once the synchronised input has disagreed
    // with it for D consecutive samples.
    logic [N-1:0]  m_p0, m_p1, m_lvl, m_press, m_rel;
    int            m_run [N];
    logic          m_valid, m_multi;
    logic [CW-1:0] m_code;

    always @(posedge clk) begin
        logic [N-1:0] s, pp, hh;
        int np;
        if (!rst_n) begin
            m_p0 = '0; m_p1 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0;
            m_valid = 1'b0; m_multi = 1'b0; m_code = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            s = m_p1;
            m_p1 = m_p0;
            m_p0 = raw_btn;
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == D) begin
                    m_lvl[i] = s[i];
                    if (s[i]) m_press[i] = 1'b1;
                    else m_rel[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
            pp = m_press; pp[0] = 1'b0;
            hh = m_lvl & ~m_press; hh[0] = 1'b0;
            np = $countones(pp);
            m_valid = (np == 1) && (hh == 0);
            m_multi = (np >= 1) && !m_valid;
            if (m_valid)
                for (int i = 1; i < N; i++)
                    if (pp[i]) m_code = CW'(i - 1);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        raw_btn = 9'h1FF;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid,
                 pat_code, multi_press, stuck} !== 41'h0) begin
                n_bad++;
                $display("FAIL reset_out got %h/%h/%h/%b/%0d/%b/%h need all 0",
                         btn_level, btn_press, btn_release, pat_valid,
                         pat_code, multi_press, stuck);
            end
        end
        rst_n = 1'b1;
        for (int j = 1; j <= 2030; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL reset_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j == 1001 || j == 1002) begin
                n_cmp++;
                if (btn_press !== (j == 1002 ? 9'h1FF : 9'h000)) begin
                    n_bad++;
                    $display("FAIL reset_latency cyc %0d press %h", j, btn_press);
                end
            end
            if (j == 1002) begin
                n_cmp++;
                if ({pat_valid, multi_press} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL reset_multi pv/mp %b%b need 01",
                             pat_valid, multi_press);
                end
            end
            if (j == 1010) raw_btn = '0;
        end
    endtask

    task automatic test_bounce();
        for (int j = 0; j <= 3100; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL bounce_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j == 1802) begin
                n_cmp++;
                if ({pat_valid, pat_code, btn_press} !== {1'b1, 3'd2, 9'h008}) begin
                    n_bad++;
                    $display("FAIL bounce_accept got %b/%0d/%h need 1/2/008",
                             pat_valid, pat_code, btn_press);
                end
            end
            if (j < 1802) begin
                n_cmp++;
                if (btn_press[3] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bounce_early cyc %0d press3 %b need 0",
                             j, btn_press[3]);
                end
            end
            if (j <= 800 && j % 200 == 0) raw_btn[3] = ~raw_btn[3];
            if (j == 2000) raw_btn[3] = 1'b0;
        end
    endtask

    task automatic test_release();
        for (int j = 0; j <= 2300; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL release_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j == 2201) begin
                n_cmp++;
                if ({btn_level[5], btn_release} !== {1'b1, 9'h000}) begin
                    n_bad++;
                    $display("FAIL release_early lvl5 %b rel %h need 1/000",
                             btn_level[5], btn_release);
                end
            end
            if (j == 2202) begin
                n_cmp++;
                if ({btn_level[5], btn_release, pat_valid} !== {1'b0, 9'h020, 1'b0}) begin
                    n_bad++;
                    $display("FAIL release_edge lvl5 %b rel %h pv %b need 0/020/0",
                             btn_level[5], btn_release, pat_valid);
                end
            end
            if (j == 0) raw_btn[5] = 1'b1;
            if (j == 1200) raw_btn[5] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j <= 2200; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL simul_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j == 1002 || j == 1003) begin
                n_cmp++;
                if ({multi_press, pat_valid, pat_code} !==
                    {(j == 1002), 1'b0, 3'd4}) begin
                    n_bad++;
                    $display("FAIL simul_multi cyc %0d mp/pv/code %b/%b/%0d",
                             j, multi_press, pat_valid, pat_code);
                end
            end
            if (j == 0) raw_btn = 9'h012;
            if (j == 1100) raw_btn = '0;
        end
    endtask

    task automatic test_held_other();
        for (int j = 0; j <= 4500; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL held_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j == 1002) begin
                n_cmp++;
                if ({pat_valid, pat_code} !== {1'b1, 3'd1}) begin
                    n_bad++;
                    $display("FAIL held_first pv/code %b/%0d need 1/1",
                             pat_valid, pat_code);
                end
            end
            if (j == 2102) begin
                n_cmp++;
                if ({btn_press, multi_press, pat_valid, pat_code} !==
                    {9'h080, 1'b1, 1'b0, 3'd1}) begin
                    n_bad++;
                    $display("FAIL held_reject press %h mp/pv/code %b/%b/%0d",
                             btn_press, multi_press, pat_valid, pat_code);
                end
            end
            if (j == 3302) begin
                n_cmp++;
                if ({btn_press, multi_press, pat_valid} !== {9'h001, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL held_start press %h mp/pv %b/%b need 001/0/0",
                             btn_press, multi_press, pat_valid);
                end
            end
            if (j == 0) raw_btn[2] = 1'b1;
            if (j == 1100) raw_btn[7] = 1'b1;
            if (j == 2300) raw_btn[0] = 1'b1;
            if (j == 3400) raw_btn = '0;
        end
    endtask

    task automatic test_random();
        int idx;
        for (int j = 0; j <= 21100; j++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({btn_level, btn_press, btn_release, pat_valid, pat_code,
                 multi_press, stuck} !== {m_lvl, m_press, m_rel, m_valid,
                 m_code, m_multi, 9'h0}) begin
                n_bad++;
                $display("FAIL random_model cyc %0d got %h/%h/%h/%b/%0d/%b exp %h/%h/%h/%b/%0d/%b",
                         j, btn_level, btn_press, btn_release, pat_valid, pat_code,
                         multi_press, m_lvl, m_press, m_rel, m_valid, m_code, m_multi);
            end
            if (j < 20000) begin
                if ($urandom_range(0, 179) == 0) begin
                    idx = int'($urandom_range(0, N - 1));
                    raw_btn[idx] = ~raw_btn[idx];
                end
                if ($urandom_range(0, 2999) == 0) raw_btn = N'($urandom);
                if ($urandom_range(0, 3999) == 0) raw_btn = '0;
            end else begin
                raw_btn = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_release();
        test_simultaneous();
        test_held_other();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
